button_pulse: RTL
=================

# button_pulse

Upstream conditioning stage for the modulo-4 counter. Takes a raw, bouncing, asynchronous pushbutton level and synchronizes and debounces it. Emits exactly one single-cycle `INC` pulse per debounced press, which drives the counter's `INC` input directly. Also exports the debounced level for LEDs or other consumers.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable synchronized samples required to accept a press or a release (5 ms at 50 MHz). Legal range ≥ 2.
- `REPEAT_CYCLES`, default 25000000: auto-repeat period in cycles while held (0.5 s at 50 MHz). Legal range ≥ 2. Used only when auto-repeat is compiled in.
- Counter width is ceil(log2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES))) bits.

Ports:
- `CLK`  in  1: system clock, rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `BTN`  in  1: raw pushbutton level, asynchronous to `CLK`, active-high.
- `INC`  out  1: registered one-cycle pulse per accepted press or repeat.
- `Pressed`  out  1: registered debounced button level.

## Operation
- Two-flop synchronizer: `BTN` → s1 → s2. All FSM decisions use s2 only.
- FSM states are IDLE, WAIT_HIGH, HIGH and WAIT_LOW, with one shared debounce counter `cnt`.
- IDLE: if s2=1, go to WAIT_HIGH and set cnt=0.
- WAIT_HIGH:
  - s2=0: go to IDLE.
  - s2=1 and cnt=DEBOUNCE_CYCLES-1: go to HIGH and assert `INC` next cycle.
  - Otherwise: cnt+1.
- HIGH: if s2=0, go to WAIT_LOW and set cnt=0.
- WAIT_LOW:
  - s2=1: return to HIGH with no pulse.
  - s2=0 and cnt=DEBOUNCE_CYCLES-1: go to IDLE.
  - Otherwise: cnt+1.
- `Pressed` = 1 in HIGH and WAIT_LOW, and 0 in IDLE and WAIT_HIGH. It is registered from next-state.
- Bounces shorter than DEBOUNCE_CYCLES on either edge produce no pulse and no `Pressed` change.
- A bounce during release (WAIT_LOW back to HIGH) never re-triggers `INC`.
- Counters saturate logically through the compare. They never wrap past their terminal value.

## Timing
- Reset (async, any state): state=IDLE, cnt=0, repeat counter=0, s1=s2=0, `INC`=0, `Pressed`=0.
- A reset mid-debounce or mid-hold discards progress. A new full debounce is then required; no pulse is emitted on reset release.
- Latency: `BTN` is first sampled high at edge 1 and stays high. `INC` is then high for exactly one cycle, starting at edge DEBOUNCE_CYCLES+3. `Pressed` rises at the same edge.
- Release latency: `BTN` is first sampled low at edge 1 and stays low. `Pressed` then falls at edge DEBOUNCE_CYCLES+3.
- `INC` is never high on two consecutive cycles.
- Minimum spacing between `INC` pulses is 2·DEBOUNCE_CYCLES+2 cycles without auto-repeat, or REPEAT_CYCLES with it.

## Configuration
- Macro: `BUTTON_PULSE_AUTOREPEAT_EN`.
- Defined:
  - In HIGH, a repeat counter increments every cycle.
  - At REPEAT_CYCLES-1 it clears and `INC` pulses for one cycle.
  - The repeat counter clears on every entry to HIGH, including a return from WAIT_LOW.
  - It holds its value (no increment) in WAIT_LOW.
- Undefined: no repeat counter is instantiated, `REPEAT_CYCLES` is ignored, and a held button yields exactly one `INC`.

## Test plan
- DEBOUNCE_CYCLES=4. Reset asserted mid-cycle → all outputs 0 immediately (asynchronously). Then `BTN`=1 held from edge 1 → `INC`=1 only in the cycle after edge 7; `Pressed`=1 from edge 7.
- DEBOUNCE_CYCLES=4. `BTN` pulses high for 3 cycles, then low → `INC` stays 0 and `Pressed` stays 0.
- DEBOUNCE_CYCLES=4. Press accepted, then release with a 2-cycle high bounce mid-release → single `INC` total. `Pressed` falls 4 stable-low samples after the last bounce.
- DEBOUNCE_CYCLES=4. `Reset` asserted in WAIT_HIGH with cnt=2, then deasserted with `BTN` still high → `INC` arrives 7 edges after reset release, not earlier.
- With `BUTTON_PULSE_AUTOREPEAT_EN`, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10, `BTN` held 40 cycles past acceptance → `INC` at acceptance, then every 10 cycles (4 repeats). Without the macro → exactly 1 `INC`.
- End to end with the modulo-4 counter: 5 clean presses → counter reads 1 (wraps 3→0 after the 4th press).

Source files
------------

// File: rtl/button_pulse.sv
// Synchronizes and debounces a raw pushbutton, emitting one INC pulse per accepted press.
// Define BUTTON_PULSE_AUTOREPEAT_EN to add periodic INC pulses while the button is held.
module button_pulse #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic CLK,
  input  logic Reset,
  input  logic BTN,
  output logic INC,
  output logic Pressed
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

  state_t        state;
  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
`ifdef BUTTON_PULSE_AUTOREPEAT_EN
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] rpt;
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= BTN;
      s2 <= s1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      INC     <= 1'b0;
      Pressed <= 1'b0;
`ifdef BUTTON_PULSE_AUTOREPEAT_EN
      rpt     <= '0;
`endif
    end else begin
      INC <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s2) begin
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            state   <= HIGH;
            INC     <= 1'b1;
            Pressed <= 1'b1;
`ifdef BUTTON_PULSE_AUTOREPEAT_EN
            rpt     <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          // A release sample takes priority over a repeat pulse on the same cycle.
          if (!s2) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
`ifdef BUTTON_PULSE_AUTOREPEAT_EN
          else if (rpt == RPT_LAST) begin
            rpt <= '0;
            INC <= 1'b1;
          end else begin
            rpt <= rpt + 1'b1;
          end
`endif
        end
        WAIT_LOW: begin
          if (s2) begin
            state <= HIGH;
`ifdef BUTTON_PULSE_AUTOREPEAT_EN
            rpt   <= '0;
`endif
          end else if (cnt == DB_LAST) begin
            state   <= IDLE;
            Pressed <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
